// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional UART baud-rate generator.
// Produces an oversample tick every (act_int + carry) cycles, where carry
// comes from a fractional accumulator, and a bit tick on every OVS-th
// oversample tick. A newly written divisor waits in pending registers and is
// only switched in at a period boundary or a phase clear, so no period is
// ever cut short or stretched by a write.
//
// Handshake: i_div_wr is a single-cycle strobe with no back-pressure. A write
// with i_div_int >= 2 is always accepted (o_div_pending or a direct apply
// follows); any other write is dropped and answered by a one-cycle o_div_err
// pulse on the next cycle.
module uart_baud_gen #(
    parameter int CNT_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int DEF_INT  = 54,
    parameter int DEF_FRAC = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_sync,
    input  logic              i_div_wr,
    input  logic [CNT_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    output logic              o_div_pending,
    output logic              o_div_err,
    output logic [CNT_W-1:0]  o_act_int,
    output logic [FRAC_W-1:0] o_act_frac,
    output logic              o_ovs_tick,
    output logic              o_bit_tick
);

    localparam int OVS_W = (OVS > 2) ? $clog2(OVS) : 1;

    // Phase state
    logic [CNT_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_frac_acc;
    logic              r_carry;
    logic [OVS_W-1:0]  r_ovs_cnt;

    // Divisor state
    logic [CNT_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [CNT_W-1:0]  r_pend_int;
    logic [FRAC_W-1:0] r_pend_frac;
    logic              r_pend;
    logic              r_err;

    logic              w_clear;
    logic [CNT_W-1:0]  w_last;
    logic              w_ovs_tick;
    logic              w_bit_tick;
    logic              w_wr_ok;
    logic              w_wr_bad;
    logic              w_apply;
    logic [FRAC_W:0]   w_frac_sum;

    // sync is meaningless while disabled, so clear covers both sources.
    assign w_clear    = ~i_en | i_sync;
    // Last count of the current period: act_int + carry cycles in total.
    assign w_last     = r_act_int - CNT_W'(1) + {{(CNT_W-1){1'b0}}, r_carry};
    assign w_ovs_tick = i_en & ~i_sync & (r_cnt == w_last);
    assign w_bit_tick = w_ovs_tick & (r_ovs_cnt == OVS_W'(OVS - 1));
    assign w_wr_ok    = i_div_wr & (i_div_int >= CNT_W'(2));
    assign w_wr_bad   = i_div_wr & (i_div_int < CNT_W'(2));
    // Period boundary or phase clear: the only moments a divisor may switch.
    assign w_apply    = w_clear | w_ovs_tick;
    // Accumulator update always uses the divisor of the period that just ended.
    assign w_frac_sum = {1'b0, r_frac_acc} + {1'b0, r_act_frac};

    // Cycle counter, fractional accumulator and oversample counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_frac_acc <= '0;
            r_carry    <= 1'b0;
            r_ovs_cnt  <= '0;
        end else if (w_clear) begin
            r_cnt      <= '0;
            r_frac_acc <= '0;
            r_carry    <= 1'b0;
            r_ovs_cnt  <= '0;
        end else if (w_ovs_tick) begin
            r_cnt      <= '0;
            r_frac_acc <= w_frac_sum[FRAC_W-1:0];
            r_carry    <= w_frac_sum[FRAC_W];
            r_ovs_cnt  <= (r_ovs_cnt == OVS_W'(OVS - 1)) ? '0 : r_ovs_cnt + OVS_W'(1);
        end else begin
            r_cnt      <= r_cnt + CNT_W'(1);
        end
    end

    // Capture of accepted writes into the pending registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_int  <= '0;
            r_pend_frac <= '0;
        end else if (w_wr_ok) begin
            r_pend_int  <= i_div_int;
            r_pend_frac <= i_div_frac;
        end
    end

    // Active divisor switch-over, pending flag and error pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_act_int  <= CNT_W'(DEF_INT);
            r_act_frac <= FRAC_W'(DEF_FRAC);
            r_pend     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_wr_bad;
            if (w_apply) begin
                // A write landing on the boundary bypasses the pending stage.
                if (w_wr_ok) begin
                    r_act_int  <= i_div_int;
                    r_act_frac <= i_div_frac;
                end else if (r_pend) begin
                    r_act_int  <= r_pend_int;
                    r_act_frac <= r_pend_frac;
                end
                r_pend <= 1'b0;
            end else if (w_wr_ok) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign o_div_pending = r_pend;
    assign o_div_err     = r_err;
    assign o_act_int     = r_act_int;
    assign o_act_frac    = r_act_frac;
    assign o_ovs_tick    = w_ovs_tick;
    assign o_bit_tick    = w_bit_tick;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: divisor-write table with the generator disabled,
// then timed scenarios whose tick positions are queued ahead and matched by
// a negedge monitor.
module tb_uart_baud_gen;

    localparam int CNT_W  = 16;
    localparam int FRAC_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              sync = 1'b0;
    logic              div_wr = 1'b0;
    logic [CNT_W-1:0]  div_int = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              div_pending;
    logic              div_err;
    logic [CNT_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic              ovs_tick;
    logic              bit_tick;

    uart_baud_gen dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_sync        (sync),
        .i_div_wr      (div_wr),
        .i_div_int     (div_int),
        .i_div_frac    (div_frac),
        .o_div_pending (div_pending),
        .o_div_err     (div_err),
        .o_act_int     (act_int),
        .o_act_frac    (act_frac),
        .o_ovs_tick    (ovs_tick),
        .o_bit_tick    (bit_tick)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_bit_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Tick monitor, sampled mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            n_vec++; n_err++;
            $display("FAIL ovs_tick_missing: got none expected tick at cycle %0d", exp_q[0]);
            void'(exp_q.pop_front());
        end
        while (exp_bit_q.size() > 0 && exp_bit_q[0] < cyc) begin
            n_vec++; n_err++;
            $display("FAIL bit_tick_missing: got none expected tick at cycle %0d", exp_bit_q[0]);
            void'(exp_bit_q.pop_front());
        end
        if (ovs_tick) begin
            n_vec++;
            if (exp_q.size() > 0 && exp_q[0] == cyc) void'(exp_q.pop_front());
            else begin
                n_err++;
                $display("FAIL ovs_tick_unexpected: got tick at cycle %0d expected none", cyc);
            end
        end
        if (bit_tick) begin
            n_vec++;
            if (exp_bit_q.size() > 0 && exp_bit_q[0] == cyc) void'(exp_bit_q.pop_front());
            else begin
                n_err++;
                $display("FAIL bit_tick_unexpected: got tick at cycle %0d expected none", cyc);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_until(input logic [31:0] c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Default divisor 54 + 4/16 from a cleared phase: periods 54,54,54,54,55
    // then 54,54,54,55 repeating; bit ticks at 867 then every 868 cycles.
    task automatic push_default(input logic [31:0] base, input int n);
        logic [31:0] cum;
        cum = 0;
        for (int k = 1; k <= n; k++) begin
            cum += ((k > 1) && (k % 4 == 1)) ? 32'd55 : 32'd54;
            exp_q.push_back(base + cum - 1);
        end
        if (n >= 16) exp_bit_q.push_back(base + 866);
        if (n >= 32) exp_bit_q.push_back(base + 866 + 868);
    endtask

    // ---------------- write table ----------------
    typedef struct {
        logic              wr;
        logic [CNT_W-1:0]  di;
        logic [FRAC_W-1:0] df;
        logic              e_err;
        logic [CNT_W-1:0]  e_int;
        logic [FRAC_W-1:0] e_frac;
    } vec_t;

    vec_t vecs[7];

    logic [31:0] t0, t33, t34, t36, e0, s0, b0, r0;

    initial begin
        // With en=0 every cycle is an apply point, so accepted writes land at once.
        vecs[0] = '{1'b1, 16'd100,   4'd3,  1'b0, 16'd100,   4'd3};
        vecs[1] = '{1'b1, 16'd1,     4'd5,  1'b1, 16'd100,   4'd3};
        vecs[2] = '{1'b0, 16'd0,     4'd0,  1'b0, 16'd100,   4'd3};
        vecs[3] = '{1'b1, 16'd2,     4'd15, 1'b0, 16'd2,     4'd15};
        vecs[4] = '{1'b1, 16'd0,     4'd0,  1'b1, 16'd2,     4'd15};
        vecs[5] = '{1'b1, 16'd65535, 4'd1,  1'b0, 16'd65535, 4'd1};
        vecs[6] = '{1'b0, 16'd0,     4'd0,  1'b0, 16'd65535, 4'd1};

        // Reset state (en high to show reset suppresses ticks).
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_act_int", 32'(act_int), 54);
        chk("rst_act_frac", 32'(act_frac), 4);
        chk("rst_pending", 32'(div_pending), 0);
        chk("rst_err", 32'(div_err), 0);
        chk("rst_ovs_tick", 32'(ovs_tick), 0);
        chk("rst_bit_tick", 32'(bit_tick), 0);

        // Table: writes while disabled.
        en  = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            div_wr   = vecs[i].wr;
            div_int  = vecs[i].di;
            div_frac = vecs[i].df;
            @(posedge clk);
            #1;
            chk("tbl_err", 32'(div_err), 32'(vecs[i].e_err));
            chk("tbl_act_int", 32'(act_int), 32'(vecs[i].e_int));
            chk("tbl_act_frac", 32'(act_frac), 32'(vecs[i].e_frac));
            chk("tbl_pending", 32'(div_pending), 0);
        end
        div_wr = 1'b0;

        // Scenario 1: reset release with default divisor.
        rst = 1'b1;
        wait_until(cyc + 2);
        rst = 1'b0;
        en  = 1'b1;
        t0  = cyc;
        push_default(t0, 33);
        t33 = t0 + 1789;

        // Scenario 2: mid-period write waits for the boundary.
        wait_until(t33 + 10);
        div_wr = 1'b1; div_int = 16'd10416; div_frac = 4'd0;
        wait_until(t33 + 11);
        div_wr = 1'b0;
        chk("wr_pending_set", 32'(div_pending), 1);
        chk("wr_act_unchanged", 32'(act_int), 54);
        t34 = t33 + 54;
        t36 = t34 + 20832;
        exp_q.push_back(t34);
        exp_q.push_back(t34 + 10416);
        exp_q.push_back(t36);
        wait_until(t34);
        chk("pending_in_tick_cycle", 32'(div_pending), 1);
        wait_until(t34 + 1);
        chk("apply_pending_clear", 32'(div_pending), 0);
        chk("apply_act_int", 32'(act_int), 10416);
        chk("apply_act_frac", 32'(act_frac), 0);

        // Scenario 3: rejected write.
        wait_until(t34 + 100);
        div_wr = 1'b1; div_int = 16'd1; div_frac = 4'd7;
        wait_until(t34 + 101);
        div_wr = 1'b0;
        chk("bad_err_pulse", 32'(div_err), 1);
        chk("bad_act_int", 32'(act_int), 10416);
        chk("bad_act_frac", 32'(act_frac), 0);
        chk("bad_pending", 32'(div_pending), 0);
        wait_until(t34 + 102);
        chk("bad_err_one_cycle", 32'(div_err), 0);

        // Scenario 5: en dropped with a write pending.
        wait_until(t36 + 20);
        div_wr = 1'b1; div_int = 16'd54; div_frac = 4'd4;
        wait_until(t36 + 21);
        div_wr = 1'b0;
        chk("en_pending_set", 32'(div_pending), 1);
        chk("en_act_old", 32'(act_int), 10416);
        wait_until(t36 + 30);
        en = 1'b0;
        wait_until(t36 + 31);
        chk("en_apply_pending", 32'(div_pending), 0);
        chk("en_apply_int", 32'(act_int), 54);
        chk("en_apply_frac", 32'(act_frac), 4);
        wait_until(t36 + 35);
        en = 1'b1;
        e0 = cyc;
        push_default(e0, 17);

        // Scenario 4: sync pulse at cnt=30 of period 18.
        s0 = e0 + 921 + 31;
        wait_until(s0);
        sync = 1'b1;
        wait_until(s0 + 1);
        sync = 1'b0;
        b0 = cyc;
        push_default(b0, 16);

        // Scenario 6: reset at cnt=20 with a write pending.
        wait_until(b0 + 880);
        div_wr = 1'b1; div_int = 16'd100; div_frac = 4'd3;
        wait_until(b0 + 881);
        div_wr = 1'b0;
        chk("rst_wr_pending", 32'(div_pending), 1);
        wait_until(b0 + 887);
        rst = 1'b1;
        #1;
        chk("midrst_ovs_tick", 32'(ovs_tick), 0);
        chk("midrst_bit_tick", 32'(bit_tick), 0);
        chk("midrst_pending", 32'(div_pending), 0);
        chk("midrst_err", 32'(div_err), 0);
        chk("midrst_act_int", 32'(act_int), 54);
        chk("midrst_act_frac", 32'(act_frac), 4);
        wait_until(b0 + 890);
        rst = 1'b0;
        r0  = cyc;
        push_default(r0, 33);
        wait_until(r0 + 1789 + 3);

        chk("ovs_queue_drained", 32'(exp_q.size()), 0);
        chk("bit_queue_drained", 32'(exp_bit_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        n_vec++; n_err++;
        $display("FAIL watchdog: got timeout expected test end");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
